// File: rtl/serv_sram_arbiter.sv
// Shares one 256x8 single-port SRAM between the SERV register file port
// and a 32-bit Wishbone host port that is serialised into byte beats.
module serv_sram_arbiter #(
    parameter int DEPTH    = 256,
    parameter int AW       = $clog2(DEPTH),
    parameter int MAX_WAIT = 4
) (
    input  logic          i_clk,
    input  logic          i_rst_n,
    input  logic          i_core_req,
    input  logic          i_core_we,
    input  logic [AW-1:0] i_core_addr,
    input  logic [7:0]    i_core_wdata,
    output logic          o_core_gnt,
    output logic          o_core_rvalid,
    output logic [7:0]    o_core_rdata,
    input  logic          i_wb_cyc,
    input  logic          i_wb_stb,
    input  logic          i_wb_we,
    input  logic [AW-3:0] i_wb_adr,
    input  logic [31:0]   i_wb_dat,
    input  logic [3:0]    i_wb_sel,
    output logic [31:0]   o_wb_rdt,
    output logic          o_wb_ack,
    output logic          o_sram_cen_n,
    output logic          o_sram_gwen_n,
    output logic [7:0]    o_sram_wen_n,
    output logic [AW-1:0] o_sram_a,
    output logic [7:0]    o_sram_d,
    input  logic [7:0]    i_sram_q
);

    typedef enum logic [1:0] {IDLE, BEAT, RDWAIT, ACK} state_e;

    localparam int WW = $clog2(MAX_WAIT + 1);
    localparam logic [WW-1:0] WMAX = WW'(MAX_WAIT);

    state_e        state_q, state_d;
    logic [AW-3:0] adr_q, adr_d;
    logic          we_q, we_d;
    logic [31:0]   dat_q, dat_d;
    logic [3:0]    sel_q, sel_d;
    logic [1:0]    k_q, k_d;
    logic [WW-1:0] wait_q, wait_d;
    logic [31:0]   rdt_q, rdt_d;
    logic          cap_vld_q, cap_vld_d;
    logic [1:0]    cap_lane_q, cap_lane_d;
    logic          rvalid_q, rvalid_d;

    logic          pending;
    logic          host_force;
    logic          core_gnt;
    logic          host_gnt;
    logic [2:0]    first;
    logic [2:0]    nxt;

    // {found, lane} of the lowest enabled lane at or above 'from'
    function automatic logic [2:0] lane_after(input logic [3:0] sel,
                                              input logic [2:0] from);
        lane_after = 3'b000;
        for (int j = 3; j >= 0; j--) begin
            if (sel[j] && 3'(j) >= from) lane_after = {1'b1, 2'(j)};
        end
    endfunction

    assign pending    = (state_q == BEAT);
    assign host_force = pending && (wait_q == WMAX);
    assign core_gnt   = i_rst_n & i_core_req & ~host_force;
    assign host_gnt   = pending & ~core_gnt;

    assign first = lane_after(i_wb_sel, 3'd0);
    assign nxt   = lane_after(sel_q, {1'b0, k_q} + 3'd1);

    assign o_core_gnt    = core_gnt;
    assign o_core_rvalid = rvalid_q;
    assign o_core_rdata  = i_sram_q;
    assign o_wb_rdt      = rdt_q;
    assign o_wb_ack      = (state_q == ACK);

    always_comb begin
        o_sram_cen_n  = 1'b1;
        o_sram_gwen_n = 1'b1;
        o_sram_wen_n  = 8'hFF;
        o_sram_a      = '0;
        o_sram_d      = 8'h00;
        if (core_gnt) begin
            o_sram_cen_n  = 1'b0;
            o_sram_gwen_n = ~i_core_we;
            o_sram_wen_n  = i_core_we ? 8'h00 : 8'hFF;
            o_sram_a      = i_core_addr;
            o_sram_d      = i_core_wdata;
        end else if (host_gnt) begin
            o_sram_cen_n  = 1'b0;
            o_sram_gwen_n = ~we_q;
            o_sram_wen_n  = we_q ? 8'h00 : 8'hFF;
            o_sram_a      = {adr_q, k_q};
            o_sram_d      = dat_q[{k_q, 3'b000} +: 8];
        end
    end

    always_comb begin
        state_d    = state_q;
        adr_d      = adr_q;
        we_d       = we_q;
        dat_d      = dat_q;
        sel_d      = sel_q;
        k_d        = k_q;
        wait_d     = wait_q;
        rdt_d      = rdt_q;
        rvalid_d   = core_gnt & ~i_core_we;
        cap_vld_d  = host_gnt & ~we_q;
        cap_lane_d = k_q;

        // lane tag registered at issue, so interleaved core cycles are harmless
        if (cap_vld_q) rdt_d[{cap_lane_q, 3'b000} +: 8] = i_sram_q;

        if (host_gnt) begin
            wait_d = '0;
        end else if (pending && core_gnt && wait_q != WMAX) begin
            wait_d = wait_q + WW'(1);
        end

        unique case (state_q)
            IDLE: begin
                if (i_wb_cyc && i_wb_stb) begin
                    adr_d = i_wb_adr;
                    we_d  = i_wb_we;
                    dat_d = i_wb_dat;
                    sel_d = i_wb_sel;
                    if (i_wb_we && !first[2]) begin
                        state_d = ACK;
                    end else begin
                        state_d = BEAT;
                        k_d     = i_wb_we ? first[1:0] : 2'd0;
                    end
                end
            end
            BEAT: begin
                if (host_gnt) begin
                    if (we_q) begin
                        if (nxt[2]) k_d = nxt[1:0];
                        else        state_d = ACK;
                    end else if (k_q == 2'd3) begin
                        state_d = RDWAIT;
                    end else begin
                        k_d = k_q + 2'd1;
                    end
                end
            end
            RDWAIT:  state_d = ACK;
            ACK:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q    <= IDLE;
            adr_q      <= '0;
            we_q       <= 1'b0;
            dat_q      <= 32'h0;
            sel_q      <= 4'h0;
            k_q        <= 2'd0;
            wait_q     <= '0;
            rdt_q      <= 32'h0;
            cap_vld_q  <= 1'b0;
            cap_lane_q <= 2'd0;
            rvalid_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            adr_q      <= adr_d;
            we_q       <= we_d;
            dat_q      <= dat_d;
            sel_q      <= sel_d;
            k_q        <= k_d;
            wait_q     <= wait_d;
            rdt_q      <= rdt_d;
            cap_vld_q  <= cap_vld_d;
            cap_lane_q <= cap_lane_d;
            rvalid_q   <= rvalid_d;
        end
    end

endmodule

// File: tb/tb_serv_sram_arbiter.sv
// Bench for serv_sram_arbiter: SRAM macro model, queue-based reference
// model compared every cycle, directed latency cases and random traffic.
module tb_serv_sram_arbiter;

    localparam int MAXW = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        core_req, core_we;
    logic [7:0]  core_addr, core_wdata;
    logic        core_gnt, core_rvalid;
    logic [7:0]  core_rdata;
    logic        wb_cyc, wb_stb, wb_we;
    logic [5:0]  wb_adr;
    logic [31:0] wb_dat;
    logic [3:0]  wb_sel;
    logic [31:0] wb_rdt;
    logic        wb_ack;
    logic        sram_cen_n, sram_gwen_n;
    logic [7:0]  sram_wen_n, sram_a, sram_d, sram_q;

    int n_chk = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    serv_sram_arbiter #(.DEPTH(256), .MAX_WAIT(MAXW)) dut (
        .i_clk(clk), .i_rst_n(rst_n),
        .i_core_req(core_req), .i_core_we(core_we),
        .i_core_addr(core_addr), .i_core_wdata(core_wdata),
        .o_core_gnt(core_gnt), .o_core_rvalid(core_rvalid),
        .o_core_rdata(core_rdata),
        .i_wb_cyc(wb_cyc), .i_wb_stb(wb_stb), .i_wb_we(wb_we),
        .i_wb_adr(wb_adr), .i_wb_dat(wb_dat), .i_wb_sel(wb_sel),
        .o_wb_rdt(wb_rdt), .o_wb_ack(wb_ack),
        .o_sram_cen_n(sram_cen_n), .o_sram_gwen_n(sram_gwen_n),
        .o_sram_wen_n(sram_wen_n), .o_sram_a(sram_a),
        .o_sram_d(sram_d), .i_sram_q(sram_q)
    );

    // SRAM macro model
    logic [7:0] sram [256];
    logic       sram_ready = 1'b0;
    always @(posedge clk) begin
        if (!sram_ready) begin
            for (int i = 0; i < 256; i++) sram[i] <= 8'h00;
            sram_ready <= 1'b1;
        end else if (!sram_cen_n) begin
            if (!sram_gwen_n)
                sram[sram_a] <= (sram[sram_a] & sram_wen_n) | (sram_d & ~sram_wen_n);
            else
                sram_q <= sram[sram_a];
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: byte memory, queue of outstanding host beats
    typedef struct packed {
        logic [7:0] a;
        logic       we;
        logic [7:0] d;
        logic [1:0] lane;
    } beat_t;

    logic [7:0]  m_mem [256];
    beat_t       hq[$];
    bit          m_init = 0;
    int          wt;
    bit          rd_wait, e_ack, e_rvalid, cap_v;
    int          cap_lane;
    logic [7:0]  cap_val, e_rdata;
    logic [31:0] e_rdt;

    initial forever begin
        @(negedge clk);
        if (!rst_n) begin
            if (!m_init) for (int i = 0; i < 256; i++) m_mem[i] = 8'h00;
            m_init = 1;
            chk("rst_cen_n", {31'b0, sram_cen_n}, 1);
            chk("rst_core_gnt", {31'b0, core_gnt}, 0);
            chk("rst_ack", {31'b0, wb_ack}, 0);
            chk("rst_rdt", wb_rdt, 0);
            chk("rst_rvalid", {31'b0, core_rvalid}, 0);
            hq.delete();
            wt = 0; rd_wait = 0; e_ack = 0; e_rvalid = 0; cap_v = 0;
            e_rdt = 32'h0;
        end else if (m_init) begin
            bit pend, cg, hg, idle, n_ack, n_rw, n_rv;
            beat_t b;
            pend = hq.size() > 0;
            cg   = core_req && !(pend && wt == MAXW);
            hg   = pend && !cg;
            chk("core_gnt", {31'b0, core_gnt}, {31'b0, cg});
            if (cg) begin
                chk("cen_core", {31'b0, sram_cen_n}, 0);
                chk("gwen_core", {31'b0, sram_gwen_n}, {31'b0, !core_we});
                chk("a_core", {24'b0, sram_a}, {24'b0, core_addr});
                if (core_we) begin
                    chk("wen_core", {24'b0, sram_wen_n}, 0);
                    chk("d_core", {24'b0, sram_d}, {24'b0, core_wdata});
                end
            end else if (hg) begin
                b = hq[0];
                chk("cen_host", {31'b0, sram_cen_n}, 0);
                chk("gwen_host", {31'b0, sram_gwen_n}, {31'b0, !b.we});
                chk("a_host", {24'b0, sram_a}, {24'b0, b.a});
                if (b.we) begin
                    chk("wen_host", {24'b0, sram_wen_n}, 0);
                    chk("d_host", {24'b0, sram_d}, {24'b0, b.d});
                end
            end else begin
                chk("cen_idle", {31'b0, sram_cen_n}, 1);
                chk("gwen_idle", {31'b0, sram_gwen_n}, 1);
                chk("wen_idle", {24'b0, sram_wen_n}, 32'hFF);
            end
            chk("ack", {31'b0, wb_ack}, {31'b0, e_ack});
            chk("rdt", wb_rdt, e_rdt);
            chk("rvalid", {31'b0, core_rvalid}, {31'b0, e_rvalid});
            if (e_rvalid) chk("core_rdata", {24'b0, core_rdata}, {24'b0, e_rdata});

            idle  = !pend && !rd_wait && !e_ack;
            n_ack = rd_wait;
            n_rw  = 0;
            if (cap_v) e_rdt[8*cap_lane +: 8] = cap_val;
            cap_v = 0;
            n_rv  = cg && !core_we;
            if (n_rv) e_rdata = m_mem[core_addr];
            if (cg && core_we) m_mem[core_addr] = core_wdata;
            if (hg) begin
                b  = hq.pop_front();
                wt = 0;
                if (b.we) m_mem[b.a] = b.d;
                else begin
                    cap_v    = 1;
                    cap_lane = int'(b.lane);
                    cap_val  = m_mem[b.a];
                end
                if (hq.size() == 0) begin
                    if (b.we) n_ack = 1;
                    else      n_rw  = 1;
                end
            end else if (pend && cg && wt < MAXW) begin
                wt++;
            end
            if (idle && wb_cyc && wb_stb) begin
                for (int l = 0; l < 4; l++)
                    if (!wb_we || wb_sel[l])
                        hq.push_back('{{wb_adr, 2'(l)}, wb_we, wb_dat[8*l +: 8], 2'(l)});
                if (wb_we && wb_sel == 4'h0) n_ack = 1;
            end
            e_ack    = n_ack;
            rd_wait  = n_rw;
            e_rvalid = n_rv;
        end
    end

    task automatic host_xfer(input logic we, input logic [5:0] adr,
                             input logic [31:0] dat, input logic [3:0] sel,
                             output int lat, output logic [31:0] rdt);
        bit got;
        wb_cyc = 1; wb_stb = 1; wb_we = we;
        wb_adr = adr; wb_dat = dat; wb_sel = sel;
        lat = -1; rdt = 32'h0; got = 0;
        for (int c = 0; c < 200; c++) begin
            @(negedge clk);
            if (wb_ack) begin
                lat = c; rdt = wb_rdt; got = 1;
                break;
            end
            @(posedge clk); #1;
        end
        chk("ack_seen", {31'b0, got}, 1);
        @(posedge clk); #1;
        wb_cyc = 0; wb_stb = 0; wb_we = 0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int lat;
        logic [31:0] r;
        bit done;
        rst_n = 0;
        core_req = 0; core_we = 0; core_addr = 0; core_wdata = 0;
        wb_cyc = 0; wb_stb = 0; wb_we = 0; wb_adr = 0; wb_dat = 0; wb_sel = 0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1;

        host_xfer(1, 6'd3, 32'hA5B6C7D8, 4'hF, lat, r);
        chk("wr_full_lat", 32'(lat), 5);
        chk("mem12", {24'b0, sram[12]}, 32'hD8);
        chk("mem15", {24'b0, sram[15]}, 32'hA5);

        host_xfer(0, 6'd3, 32'h0, 4'hF, lat, r);
        chk("rd_full_lat", 32'(lat), 6);
        chk("rd_full_data", r, 32'hA5B6C7D8);

        host_xfer(1, 6'd3, 32'h11223344, 4'b0101, lat, r);
        chk("wr_0101_lat", 32'(lat), 3);
        host_xfer(1, 6'd3, 32'hFFFFFFFF, 4'b0000, lat, r);
        chk("wr_sel0_lat", 32'(lat), 1);
        host_xfer(0, 6'd3, 32'h0, 4'b0001, lat, r);
        chk("rd_after_partial", r, 32'hA522C744);

        fork
            host_xfer(0, 6'd3, 32'h0, 4'hF, lat, r);
            begin
                core_req = 1; core_we = 0;
                repeat (30) begin
                    core_addr = 8'($urandom);
                    @(posedge clk); #1;
                end
                core_req = 0;
            end
        join
        chk("contended_lat", 32'(lat), 22);
        chk("contended_data", r, 32'hA522C744);

        core_req = 1; core_we = 1; core_addr = 8'd7; core_wdata = 8'h5A;
        @(posedge clk); #1;
        core_we = 0;
        @(posedge clk); #1;
        core_req = 0;
        @(negedge clk);
        chk("core_rvalid_pulse", {31'b0, core_rvalid}, 1);
        chk("core_rdata_5a", {24'b0, core_rdata}, 32'h5A);
        @(posedge clk); #1;

        wb_cyc = 1; wb_stb = 1; wb_we = 0; wb_adr = 6'd3; wb_sel = 4'hF;
        repeat (2) begin @(posedge clk); #1; end
        rst_n = 0; wb_cyc = 0; wb_stb = 0;
        @(negedge clk);
        chk("midrst_rdt", wb_rdt, 0);
        @(posedge clk); #1 rst_n = 1;
        repeat (8) begin
            @(negedge clk);
            chk("no_ack_after_rst", {31'b0, wb_ack}, 0);
        end
        @(posedge clk); #1;
        host_xfer(0, 6'd3, 32'h0, 4'hF, lat, r);
        chk("post_rst_lat", 32'(lat), 6);
        chk("post_rst_data", r, 32'hA522C744);

        repeat (60) begin
            done = 0;
            fork
                begin
                    host_xfer(1'($urandom), 6'($urandom), $urandom,
                              4'($urandom), lat, r);
                    done = 1;
                end
                begin
                    while (!done) begin
                        core_req   = ($urandom_range(0, 2) != 0);
                        core_we    = 1'($urandom);
                        core_addr  = 8'($urandom);
                        core_wdata = 8'($urandom);
                        @(posedge clk); #1;
                    end
                    core_req = 0;
                end
            join
            if ($urandom_range(0, 3) == 0) begin
                @(posedge clk); #1;
            end
        end
        repeat (3) begin @(posedge clk); #1; end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/serv_sram_arbiter.md
Name: serv_sram_arbiter

Overview:
- Controller that shares one gf180 256x8 single-port SRAM macro between two requesters.
- SERV core register-file port: byte wide, high priority, one access per cycle.
- Host Wishbone classic port: 32-bit; each host word becomes up to 4 sequential byte beats.
- Sits between serv_rf_ram-style users and the macro, so the management core can inspect or preload the register file.

Parameters:
- DEPTH, 256, SRAM depth in bytes; must be a power of two, >=8.
- AW, $clog2(DEPTH), SRAM byte address width.
- MAX_WAIT, 4, consecutive cycles a pending host beat may lose to the core before it is forced through; must be >=1.

Ports:
- i_clk  in  1  clock
- i_rst_n  in  1  asynchronous active-low reset
- i_core_req  in  1  core access request this cycle
- i_core_we  in  1  1=write, 0=read
- i_core_addr  in  AW  byte address
- i_core_wdata  in  8  write data
- o_core_gnt  out  1  combinational; access performed this cycle when high
- o_core_rvalid  out  1  registered; o_core_rdata valid this cycle
- o_core_rdata  out  8  equals i_sram_q
- i_wb_cyc, i_wb_stb, i_wb_we  in  1 each  Wishbone classic control
- i_wb_adr  in  AW-2  word address
- i_wb_dat  in  32  write data, little-endian bytes
- i_wb_sel  in  4  byte enables
- o_wb_rdt  out  32  read data
- o_wb_ack  out  1  single-cycle acknowledge
- o_sram_cen_n  out  1  active-low chip enable
- o_sram_gwen_n  out  1  active-low global write enable
- o_sram_wen_n  out  8  active-low bit write mask
- o_sram_a  out  AW  address
- o_sram_d  out  8  write data
- i_sram_q  in  8  read data, valid the cycle after a read is clocked

Behaviour:
- Reset values: state=IDLE, o_wb_ack=0, o_wb_rdt=0, o_core_rvalid=0, wait_cnt=0, beat index=0.
- In reset: o_sram_cen_n=1, o_core_gnt=0.
- SRAM outputs are combinational from the granted requester.
- Nothing granted: cen_n=1, gwen_n=1, wen_n=8'hFF.
- Grant:
  - Host beat pending and wait_cnt==MAX_WAIT: host wins, o_core_gnt=0.
  - Otherwise core wins whenever i_core_req=1.
  - Host is granted only when its beat is pending and the core is not granted.
- wait_cnt:
  - +1 each cycle a host beat is pending and the core is granted.
  - Cleared when a host beat issues.
  - Saturates at MAX_WAIT.
- Core write: gwen_n=0, wen_n=8'h00. Core read: gwen_n=1.
- o_core_rvalid <= core granted read. Host reads never assert it.
- Host FSM states: IDLE, BEAT, RDWAIT, ACK.
  - IDLE: when cyc&stb, latch adr/we/dat/sel. If write with sel==0, go to ACK; otherwise go to BEAT with beat k = first needed lane.
  - BEAT, beat k: SRAM address is {adr,k[1:0]}.
    - Writes: only lanes with sel[k]=1 issue; zero lanes are skipped with no cycle cost.
    - Reads: all 4 lanes issue, regardless of sel.
    - On host grant: write beats end at the last set lane, then go to ACK. Read beats advance k; after k=3, go to RDWAIT.
  - Read capture: the cycle after read beat k issues, i_sram_q is stored into o_wb_rdt[8k+7:8k]. Capture uses a registered lane tag, so core cycles interleaved between host beats do not corrupt it. RDWAIT captures lane 3, then goes to ACK.
  - ACK: o_wb_ack=1 for exactly one cycle; o_wb_rdt is stable and holds until the next read. Then return to IDLE.
  - Requests are not re-sampled in the ACK cycle.
- Uncontended latency from the stb-sampled cycle (cycle 0):
  - Full read: ack at cycle 6.
  - Full write: ack at cycle 5.
  - Write with sel=0: ack at cycle 1.
- cyc dropped mid-transaction: remaining beats still complete and ack is still pulsed. The master must ignore it.
- Core and host targeting the same address in different cycles: strict issue order; no forwarding.
- Reset asserted mid-operation: immediate return to IDLE; in-flight host transaction discarded with no ack.
- Address widths: core uses the full AW bits; host lane bits are the low 2 bits.

Test Plan:
- Idle core; host writes 0xA5B6C7D8 to word 3 with sel=1111 -> SRAM writes 0xD8,0xC7,0xB6,0xA5 at 12,13,14,15 in cycles 1-4; ack at cycle 5.
- Host reads word 3 afterwards -> o_wb_rdt=0xA5B6C7D8 with ack at cycle 6; o_core_rvalid stays 0.
- Host write with sel=0101 -> writes only to addresses 12 and 14; ack at cycle 3. sel=0000 -> no SRAM write; ack at cycle 1.
- Core requests continuously during a host read with MAX_WAIT=4 -> each host beat issues after exactly 4 core grants, o_core_gnt=0 in that cycle, and the read data is correct.
- Core writes 0x5A to address 7, then reads it -> o_core_rvalid pulses the cycle after the read grant with o_core_rdata=0x5A.
- i_rst_n pulsed low mid host read -> outputs return to reset values; no ack; the next host request completes normally.
